axi_apb_bridge: RTL and testbench
=================================

// Module: axi_apb_bridge
// PURPOSE
//  Upstream APB master feeding the peripheral slaves (GPIO, etc.) from the CPU's AXI4-Lite port.
//  Accepts one AXI4-Lite read or write at a time and runs one APB SETUP/ACCESS cycle.
//  Decodes the target slave from address bits and returns the AXI response.
//  A watchdog terminates any APB access whose slave never asserts Pready.
// PARAMETERS
//  NSLV     4    number of APB slaves (1..8)
//  SEL_LSB  8    lowest Paddr bit of the slave index field; index = addr[SEL_LSB +: 3]
//  TIMEOUT  255  max ACCESS cycles without Pready before SLVERR (8-bit counter)
// PORTS
//  clock    in   1        single clock, all logic on posedge
//  reset    in   1        synchronous, active-low
//  AWADDR   in   32       write address;  AWVALID in 1;  AWREADY out 1
//  WDATA    in   32       write data;  WSTRB in 4;  WVALID in 1;  WREADY out 1
//  BRESP    out  2        write response;  BVALID out 1;  BREADY in 1
//  ARADDR   in   32       read address;  ARVALID in 1;  ARREADY out 1
//  RDATA    out  32       read data;  RRESP out 2;  RVALID out 1;  RREADY in 1
//  Paddr    out  32       APB address, held SETUP through ACCESS
//  Psel     out  NSLV     one-hot slave select
//  Penable  out  1        high in ACCESS phase only
//  Pwrite   out  1        1 = write
//  Pwdata   out  32       write data;  strobe out 4 = WSTRB copy
//  Pready   in   NSLV     per-slave ready
//  Prdata   in   32*NSLV  per-slave read data, slave k at [32k +: 32]
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; rd_prio = 0 (write wins first tie).
//  FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; ERR state for decode errors.
//  IDLE: write eligible iff AWVALID && WVALID; read eligible iff ARVALID.
//   - Both eligible: rd_prio picks; rd_prio toggles after every accepted transaction.
//   - Accept cycle: AWREADY=WREADY=1 (or ARREADY=1) combinationally for one cycle.
//   - Addr/data/strb/dir are registered on the same edge.
//   - AWVALID without WVALID (or vice versa): nothing accepted; wait.
//  Decode: index >= NSLV -> ERR: no APB cycle; next edge respond DECERR (2'b11), RDATA = 0.
//  SETUP (1 cycle): Psel[idx]=1, Penable=0, Paddr/Pwrite/Pwdata/strobe valid.
//  ACCESS: Penable=1; all APB outputs held stable.
//   - Leave on the edge where Pready[idx]=1; read latches Prdata[idx], RESP=OKAY (2'b00).
//   - Watchdog counts ACCESS cycles; at TIMEOUT with no Pready: drop Psel/Penable, SLVERR (2'b10), RDATA = 0.
//  Psel/Penable fall the cycle after completion (never two back-to-back SETUPs without IDLE).
//  RESP: BVALID or RVALID held with data/resp stable until BREADY/RREADY; then IDLE.
//  Min latency, write: accept @N, SETUP N+1, ACCESS N+2 (Pready=1), BVALID N+3.
//  Read latency is identical, with RVALID at N+3.
//  Pready of non-selected slaves is ignored; Pready during SETUP is ignored.
//  Reset low mid-transaction: next edge -> IDLE, Psel/Penable/valids 0, transaction discarded, no response.
//  No new AXI request is accepted while any transaction is in flight (single outstanding).
// STRUCTURE
//  Shared header apb_bridge_defs.vh: state encodings (IDLE, SETUP, ACCESS, RESP, ERR).
//  Same header: RESP_OKAY 2'b00, RESP_SLVERR 2'b10, RESP_DECERR 2'b11.
//  Sub-module apb_slave_decode: addr -> one-hot Psel vector + dec_err flag (combinational).
//  Top holds FSM, arbiter flag, watchdog counter, capture registers, response registers.
// TESTING
//  1 Write AWADDR=0x100 (slave 1) WDATA=0x5 WSTRB=0xF, Pready[1]=1 in ACCESS
//    -> Psel=4'b0010, Pwdata=0x5, BVALID @N+3, BRESP=00.
//  2 Read ARADDR=0x200, Pready[2] low 3 ACCESS cycles then high, Prdata[2]=0xA5
//    -> Penable high 4 cycles, RDATA=0xA5, RRESP=00.
//  3 NSLV=4, ARADDR=0x500 -> no Psel ever asserted, RVALID with RRESP=11, RDATA=0.
//  4 Pready never asserted, TIMEOUT=255 -> Psel drops after 255 ACCESS cycles, BRESP=10.
//  5 AW+W and AR valid same cycle, twice -> write served first, then read (alternation).
//  6 Reset low during ACCESS -> next edge Psel=0, Penable=0, no BVALID; next request completes normally.

Source files
------------

// File: rtl/axi_apb_bridge_pkg.sv
// Shared definitions for the AXI4-Lite to APB bridge: FSM encodings, response codes
// and the captured-request record.
package axi_apb_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int IDX_W  = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_RESP   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              write;
  } apb_req_t;

endpackage

// File: rtl/axi_apb_bridge_slave_decode.sv
// Address-to-slave decoder: one-hot select from the index field plus a flag for
// indices that have no slave behind them.
module apb_slave_decode
  import axi_apb_bridge_pkg::*;
#(
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 8
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NSLV-1:0]   psel_o,
  output logic              dec_err_o
);

  logic [IDX_W-1:0] idx;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    idx       = addr_i[SEL_LSB +: IDX_W];
    dec_err_o = (int'(idx) >= NSLV);
    psel_o    = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx == IDX_W'(k)) psel_o[k] = 1'b1;
    end
  end

endmodule

// File: rtl/axi_apb_bridge.sv
// Single-outstanding AXI4-Lite slave that replays each request as one APB
// SETUP/ACCESS transfer, with a watchdog on slaves that never signal ready.
module axi_apb_bridge
  import axi_apb_bridge_pkg::*;
#(
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [ADDR_W-1:0]      awaddr_i,
  input  logic                   awvalid_i,
  output logic                   awready_o,
  input  logic [DATA_W-1:0]      wdata_i,
  input  logic [STRB_W-1:0]      wstrb_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  output logic [1:0]             bresp_o,
  output logic                   bvalid_o,
  input  logic                   bready_i,
  input  logic [ADDR_W-1:0]      araddr_i,
  input  logic                   arvalid_i,
  output logic                   arready_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic [1:0]             rresp_o,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [ADDR_W-1:0]      paddr_o,
  output logic [NSLV-1:0]        psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [DATA_W-1:0]      pwdata_o,
  output logic [STRB_W-1:0]      strobe_o,
  input  logic [NSLV-1:0]        pready_i,
  input  logic [DATA_W*NSLV-1:0] prdata_i
);

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  apb_req_t          req_q, req_d;
  logic [NSLV-1:0]   sel_q, sel_d;
  logic              rd_prio_q, rd_prio_d;
  logic [7:0]        wdog_q, wdog_d;
  logic [1:0]        resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              wr_elig, take_wr, take_rd;
  logic [ADDR_W-1:0] in_addr;
  logic [NSLV-1:0]   dec_sel;
  logic              dec_err;
  logic              slv_ready;
  logic [DATA_W-1:0] slv_rdata;

  // Arbitration only happens in IDLE; rd_prio breaks write/read ties.
  always_comb begin
    wr_elig = awvalid_i && wvalid_i;
    take_rd = (state_q == ST_IDLE) && arvalid_i && (!wr_elig || rd_prio_q);
    take_wr = (state_q == ST_IDLE) && wr_elig && !take_rd;
    in_addr = take_rd ? araddr_i : awaddr_i;
  end

  apb_slave_decode #(
    .NSLV    (NSLV),
    .SEL_LSB (SEL_LSB)
  ) u_decode (
    .addr_i    (in_addr),
    .psel_o    (dec_sel),
    .dec_err_o (dec_err)
  );

  always_comb begin
    slv_ready = |(pready_i & sel_q);
    slv_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q[k]) slv_rdata = prdata_i[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    sel_d     = sel_q;
    rd_prio_d = rd_prio_q;
    wdog_d    = wdog_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (take_wr || take_rd) begin
          req_d.addr  = in_addr;
          req_d.data  = wdata_i;
          req_d.strb  = wstrb_i;
          req_d.write = take_wr;
          sel_d       = dec_sel;
          rd_prio_d   = !rd_prio_q;
          state_d     = dec_err ? ST_ERR : ST_SETUP;
        end
      end
      ST_SETUP: begin
        wdog_d  = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (slv_ready) begin
          resp_d  = RESP_OKAY;
          rdata_d = req_q.write ? '0 : slv_rdata;
          state_d = ST_RESP;
        end else if (wdog_q == WDOG_LAST) begin
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      ST_ERR: begin
        resp_d  = RESP_DECERR;
        rdata_d = '0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (req_q.write ? bready_i : rready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so each register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      sel_q     <= '0;
      rd_prio_q <= 1'b0;
      wdog_q    <= '0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      sel_q     <= sel_d;
      rd_prio_q <= rd_prio_d;
      wdog_q    <= wdog_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign awready_o = take_wr;
  assign wready_o  = take_wr;
  assign arready_o = take_rd;

  assign psel_o    = (state_q == ST_SETUP || state_q == ST_ACCESS) ? sel_q : '0;
  assign penable_o = (state_q == ST_ACCESS);
  assign paddr_o   = req_q.addr;
  assign pwrite_o  = req_q.write;
  assign pwdata_o  = req_q.data;
  assign strobe_o  = req_q.strb;

  assign bvalid_o  = (state_q == ST_RESP) && req_q.write;
  assign rvalid_o  = (state_q == ST_RESP) && !req_q.write;
  assign bresp_o   = resp_q;
  assign rresp_o   = resp_q;
  assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_axi_apb_bridge.sv
// Randomized bench for axi_apb_bridge: a transaction-level model predicts arbitration
// order, response code, read data, ACCESS length and response latency.
module tb_axi_apb_bridge;

  localparam int NSLV    = 4;
  localparam int SEL_LSB = 8;
  localparam int TIMEOUT = 255;
  localparam int MAX_CYC = 400;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [31:0]          awaddr, wdata, araddr, rdata, paddr, pwdata;
  logic                 awvalid, awready, wvalid, wready, bvalid, bready;
  logic                 arvalid, arready, rvalid, rready;
  logic [3:0]           wstrb, strobe;
  logic [1:0]           bresp, rresp;
  logic [NSLV-1:0]      psel, pready;
  logic                 penable, pwrite;
  logic [32*NSLV-1:0]   prdata;

  int          checks = 0;
  int          errors = 0;
  bit          prio_m;
  logic [31:0] w_addr, w_data, r_addr;
  logic [3:0]  w_strb;
  logic [31:0] slave_data [NSLV];

  always #5 clk = ~clk;

  axi_apb_bridge #(.NSLV(NSLV), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .strobe_o(strobe), .pready_i(pready), .prdata_i(prdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[SEL_LSB +: 3] = 3'($urandom_range(0, 7));
    return a;
  endfunction

  // Runs one transaction to completion; do_wr/do_rd say which requests are presented.
  task automatic run_txn(input bit do_wr, input bit do_rd, input int delay);
    bit srv_wr, dec, acc, done, rsp_seen, psel_seen, other_rdy, unstable, bad_apb, wrong_vld;
    bit vld, rdy, srv_rdy;
    int idx, acc_cyc, rsp_cyc, pen, exp_pen;
    logic [31:0] a, rsp_data, s_paddr, s_pwdata, exp_data, exp_sel;
    logic [NSLV-1:0] s_psel;
    logic s_pwrite;
    logic [3:0] s_strb;
    logic [1:0] rsp_code, exp_code;
    acc = 0; done = 0; rsp_seen = 0; psel_seen = 0; other_rdy = 0; unstable = 0;
    bad_apb = 0; wrong_vld = 0; acc_cyc = 0; rsp_cyc = 0; pen = 0;
    rsp_data = '0; rsp_code = '0; s_psel = '0; s_paddr = '0; s_pwdata = '0;
    s_pwrite = 0; s_strb = '0;
    srv_wr = do_wr && (!do_rd || !prio_m);
    a   = srv_wr ? w_addr : r_addr;
    idx = int'(a[SEL_LSB +: 3]);
    dec = (idx >= NSLV);
    for (int cyc = 0; cyc < MAX_CYC && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        for (int k = 0; k < NSLV; k++) begin
          slave_data[k] = $urandom;
          prdata[32*k +: 32] = slave_data[k];
        end
        if (do_wr) begin
          awaddr = w_addr; wdata = w_data; wstrb = w_strb; awvalid = 1; wvalid = 1;
        end
        if (do_rd) begin
          araddr = r_addr; arvalid = 1;
        end
      end else if (acc) begin
        if (srv_wr) begin awvalid = 0; wvalid = 0; end
        else arvalid = 0;
      end
      bready = 1'($urandom_range(0, 1));
      rready = 1'($urandom_range(0, 1));
      #1;
      srv_rdy = srv_wr ? (awready && wready) : arready;
      if (!acc && srv_rdy) begin
        acc = 1; acc_cyc = cyc;
        if (srv_wr ? arready : (awready || wready)) other_rdy = 1;
      end else if (awready || wready || arready) other_rdy = 1;
      if (psel != '0) begin
        if (!psel_seen) begin
          psel_seen = 1; s_psel = psel; s_paddr = paddr; s_pwrite = pwrite;
          s_pwdata = pwdata; s_strb = strobe;
          if (penable) bad_apb = 1;
        end else if (psel !== s_psel || paddr !== s_paddr || pwrite !== s_pwrite ||
                     pwdata !== s_pwdata || strobe !== s_strb) unstable = 1;
        if (penable) pen++;
      end else if (penable) bad_apb = 1;
      pready = NSLV'($urandom);
      if (!dec && penable && psel != '0) pready[idx] = (pen == delay + 1);
      vld = srv_wr ? bvalid : rvalid;
      rdy = srv_wr ? bready : rready;
      if (srv_wr ? rvalid : bvalid) wrong_vld = 1;
      if (vld) begin
        if (!rsp_seen) begin
          rsp_seen = 1; rsp_cyc = cyc; rsp_code = srv_wr ? bresp : rresp; rsp_data = rdata;
        end else if ((srv_wr ? bresp : rresp) !== rsp_code ||
                     (!srv_wr && rdata !== rsp_data)) unstable = 1;
        if (rdy) done = 1;
      end
    end
    if (dec) begin
      exp_code = 2'b11; exp_pen = 0;
    end else if (delay + 1 <= TIMEOUT) begin
      exp_code = 2'b00; exp_pen = delay + 1;
    end else begin
      exp_code = 2'b10; exp_pen = TIMEOUT;
    end
    exp_data = '0;
    if (!srv_wr && exp_code == 2'b00) exp_data = slave_data[idx];
    exp_sel = dec ? 32'd0 : (32'd1 << idx);
    check("accepted", 32'(acc), 32'd1);
    check("completed", 32'(done), 32'd1);
    check("single_outstanding", 32'(other_rdy), 32'd0);
    check("resp_code", 32'(rsp_code), 32'(exp_code));
    check("access_cycles", 32'(pen), 32'(exp_pen));
    check("latency", 32'(rsp_cyc - acc_cyc), 32'(2 + exp_pen));
    check("psel", 32'(s_psel), exp_sel);
    check("stable", 32'(unstable), 32'd0);
    check("apb_phase", 32'(bad_apb), 32'd0);
    check("wrong_channel_valid", 32'(wrong_vld), 32'd0);
    if (!srv_wr) check("rdata", rsp_data, exp_data);
    if (!dec) begin
      check("paddr", s_paddr, a);
      check("pwrite", 32'(s_pwrite), 32'(srv_wr));
      if (srv_wr) begin
        check("pwdata", s_pwdata, w_data);
        check("strobe", 32'(s_strb), 32'(w_strb));
      end
    end
    if (acc) prio_m = !prio_m;
  endtask

  // Presents write and read together, then lets the loser complete.
  task automatic run_pair(input int d0, input int d1);
    bit first_wr;
    first_wr = !prio_m;
    run_txn(1, 1, d0);
    if (first_wr) run_txn(0, 1, d1);
    else run_txn(1, 0, d1);
  endtask

  initial begin
    bit flag;
    rst_n = 0; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0; pready = '0; prdata = '0; prio_m = 0;
    repeat (2) @(negedge clk);
    check("rst_psel", 32'(psel), 32'd0);
    check("rst_penable", 32'(penable), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_ready", 32'({awready, wready, arready}), 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst_n = 1;

    w_addr = 32'h100; w_data = 32'h5; w_strb = 4'hF;
    run_txn(1, 0, 0);
    r_addr = 32'h200;
    run_txn(0, 1, 3);
    r_addr = 32'h500;
    run_txn(0, 1, 0);
    w_addr = 32'h0000_0040; w_data = $urandom;
    run_txn(1, 0, 300);

    w_addr = 32'h0000_0304; w_data = $urandom; r_addr = 32'h0000_0108;
    run_pair(0, 1);
    w_addr = 32'h0000_0210; w_data = $urandom; r_addr = 32'h0000_0020;
    run_pair(2, 0);

    // Half a write request must never be accepted.
    @(negedge clk);
    awaddr = 32'h100; awvalid = 1; wvalid = 0; flag = 0;
    repeat (3) begin
      #1; if (awready || wready || psel != '0) flag = 1;
      @(negedge clk);
    end
    awvalid = 0; wvalid = 1;
    repeat (3) begin
      #1; if (awready || wready || psel != '0) flag = 1;
      @(negedge clk);
    end
    wvalid = 0;
    check("half_write_ignored", 32'(flag), 32'd0);

    // Reset in the middle of ACCESS discards the transaction.
    awaddr = 32'h0000_0004; wdata = 32'hDEAD_BEEF; wstrb = 4'h3; awvalid = 1; wvalid = 1;
    pready = '0; bready = 1;
    #1;
    check("rst_mid_accept", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 0; wvalid = 0; flag = 0;
    for (int i = 0; i < 10 && !flag; i++) begin
      @(negedge clk);
      if (penable) flag = 1;
    end
    @(negedge clk);
    check("rst_mid_in_access", 32'(penable), 32'd1);
    rst_n = 0;
    @(negedge clk);
    check("rst_mid_psel", 32'(psel), 32'd0);
    check("rst_mid_penable", 32'(penable), 32'd0);
    check("rst_mid_bvalid", 32'(bvalid), 32'd0);
    rst_n = 1; prio_m = 0; flag = 0;
    repeat (5) begin
      @(negedge clk);
      if (bvalid || rvalid || psel != '0) flag = 1;
    end
    check("rst_mid_no_resp", 32'(flag), 32'd0);
    w_addr = 32'h0000_0104; w_data = $urandom; w_strb = 4'hA;
    run_txn(1, 0, 1);

    for (int n = 0; n < 40; n++) begin
      int kind;
      kind   = $urandom_range(0, 2);
      w_addr = rand_addr(); w_data = $urandom; w_strb = 4'($urandom);
      r_addr = rand_addr();
      if (kind == 2) run_pair($urandom_range(0, 4), $urandom_range(0, 4));
      else run_txn(kind == 0, kind == 1, $urandom_range(0, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
